mult_array_pipe: RTL

Parametrised, fully pipelined element-wise fixed-point multiplier array for the IK matrix datapath. Multiplies ROWS×COLS pairs of signed Q-format operands per beat, rounds each product back to operand width, and streams the result under a valid/ready handshake with back-pressure. A sideband tag travels with each beat so the matrix sequencer can match results to issued operations. It replaces the free-running, enable-only multiplier array with stall-safe flow control and overflow reporting.

---
 rtl/mult_array_pipe.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mult_array_pipe.sv
// Pipelined element-wise signed fixed-point multiplier array with valid/ready flow control,
// round-half-up to operand width and overflow flag. Define MULT_ARRAY_SAT_EN to saturate instead of wrap.
module mult_array_pipe #(
    parameter int ROWS        = 6,
    parameter int COLS        = 6,
    parameter int W           = 27,
    parameter int F           = 16,
    parameter int MULT_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ROWS*COLS*W-1:0]   in_a,
    input  logic [ROWS*COLS*W-1:0]   in_b,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ROWS*COLS*W-1:0]   out_p,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_ovf,
    output logic                     busy
);

    localparam int N  = ROWS * COLS;
    localparam int PW = 2 * W;
    localparam int RW = PW - F + 1;
    localparam int S  = MULT_STAGES;

    // Handshake: a beat moves on an edge only when adv is high; adv is low exactly
    // when the output holds a valid beat that the consumer has not taken.
    logic adv;

    logic [S-1:0]           vld_q;
    logic [TAG_W-1:0]       tag_q  [S];
    logic signed [PW-1:0]   prod_q [S][N];
    logic signed [PW-1:0]   prod_d [N];

    logic signed [RW-1:0]   rnd;
    logic [W-F+1:0]         rnd_hi;
    logic                   elem_ovf;
    logic [N*W-1:0]         res_d;
    logic                   ovf_d;

    logic                   out_valid_q;
    logic [N*W-1:0]         out_p_q;
    logic [TAG_W-1:0]       out_tag_q;
    logic                   out_ovf_q;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;
    assign busy     = (|vld_q) || out_valid_q;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            prod_d[k] = PW'($signed(in_a[k*W +: W])) * PW'($signed(in_b[k*W +: W]));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int s = 0; s < S; s++) begin
                tag_q[s] <= '0;
                for (int k = 0; k < N; k++) prod_q[s][k] <= '0;
            end
        end else if (adv) begin
            vld_q[0] <= in_valid;
            if (in_valid) begin
                tag_q[0] <= in_tag;
                for (int k = 0; k < N; k++) prod_q[0][k] <= prod_d[k];
            end
            for (int s = 1; s < S; s++) begin
                vld_q[s] <= vld_q[s-1];
                if (vld_q[s-1]) begin
                    tag_q[s] <= tag_q[s-1];
                    for (int k = 0; k < N; k++) prod_q[s][k] <= prod_q[s-1][k];
                end
            end
        end
    end

    // Rounded value kept wide; it fits W bits iff its top W-F+2 bits are all equal.
    always_comb begin
        res_d    = '0;
        ovf_d    = 1'b0;
        rnd      = '0;
        rnd_hi   = '0;
        elem_ovf = 1'b0;
        for (int k = 0; k < N; k++) begin
            rnd      = RW'(prod_q[S-1][k] >>> F) + RW'(prod_q[S-1][k][F-1]);
            rnd_hi   = rnd[RW-1:W-1];
            elem_ovf = (|rnd_hi) && !(&rnd_hi);
            ovf_d    = ovf_d || elem_ovf;
`ifdef MULT_ARRAY_SAT_EN
            if (elem_ovf) begin
                res_d[k*W +: W] = rnd[RW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            end else begin
                res_d[k*W +: W] = rnd[W-1:0];
            end
`else
            res_d[k*W +: W] = rnd[W-1:0];
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_p_q     <= '0;
            out_tag_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else if (adv) begin
            out_valid_q <= vld_q[S-1];
            if (vld_q[S-1]) begin
                out_p_q   <= res_d;
                out_tag_q <= tag_q[S-1];
                out_ovf_q <= ovf_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_p     = out_p_q;
    assign out_tag   = out_tag_q;
    assign out_ovf   = out_ovf_q;

endmodule
